// File: rtl/rotary_encoder.sv
// Quadrature rotary encoder front end: two-flop synchronizers, per-channel
// debounce, a short power-up sequence and a modulo-4 signed position with
// one-cycle step/glitch pulses. All outputs come straight from registers.
module rotary_encoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INVERT          = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enc_a,
  input  logic              enc_b,
  output logic signed [1:0] encoder_value,
  output logic              step_cw,
  output logic              step_ccw,
  output logic              glitch
);

  typedef enum logic [1:0] {
    INIT0 = 2'd0,
    INIT1 = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  // Direction of a single-channel move on the stable {a,b} pair.
  // Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic is_forward(input logic a_moved, input logic a_old,
                                      input logic b_old, input logic a_new,
                                      input logic b_new);
    logic fwd;
    if (a_moved) begin
      fwd = a_new ^ b_old;
    end else begin
      fwd = ~(b_new ^ a_old);
    end
    return fwd;
  endfunction

  state_t      r_state;
  state_t      w_state_next;
  logic        r_a_meta, r_a_sync, r_b_meta, r_b_sync;
  logic        r_a_stable, r_b_stable;
  logic        w_a_stable_next, w_b_stable_next;
  logic [15:0] r_a_cnt, r_b_cnt;
  logic [15:0] w_a_cnt_next, w_b_cnt_next;
  logic [1:0]  r_value, w_value_next;
  logic        r_step_cw, r_step_ccw, r_glitch;
  logic        w_cw_next, w_ccw_next, w_glitch_next;
  logic        w_a_accept, w_b_accept, w_fwd;

  // Two-flop synchronizers: the only logic that touches the raw pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= enc_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= enc_b;
      r_b_sync <= r_b_meta;
    end
  end

  // Next-state, debounce and output decode; everything defaults to "hold".
  always_comb begin
    w_state_next    = r_state;
    w_a_stable_next = r_a_stable;
    w_b_stable_next = r_b_stable;
    w_a_cnt_next    = r_a_cnt;
    w_b_cnt_next    = r_b_cnt;
    w_value_next    = r_value;
    w_cw_next       = 1'b0;
    w_ccw_next      = 1'b0;
    w_glitch_next   = 1'b0;
    w_a_accept      = 1'b0;
    w_b_accept      = 1'b0;
    w_fwd           = 1'b0;
    case (r_state)
      INIT0: begin
        w_state_next = INIT1;
        w_a_cnt_next = 16'd0;
        w_b_cnt_next = 16'd0;
      end
      INIT1: begin
        // Load from the first flop: that is what the sync flop holds after
        // this edge, so a pin steady across reset release never looks like
        // a pending change once RUN starts.
        w_state_next    = RUN;
        w_a_stable_next = r_a_meta;
        w_b_stable_next = r_b_meta;
        w_a_cnt_next    = 16'd0;
        w_b_cnt_next    = 16'd0;
      end
      RUN: begin
        w_state_next = RUN;
        if (r_a_sync == r_a_stable) begin
          w_a_cnt_next = 16'd0;
        end else if (r_a_cnt == CNT_MAX) begin
          w_a_accept      = 1'b1;
          w_a_stable_next = r_a_sync;
          w_a_cnt_next    = 16'd0;
        end else begin
          w_a_cnt_next = r_a_cnt + 16'd1;
        end
        if (r_b_sync == r_b_stable) begin
          w_b_cnt_next = 16'd0;
        end else if (r_b_cnt == CNT_MAX) begin
          w_b_accept      = 1'b1;
          w_b_stable_next = r_b_sync;
          w_b_cnt_next    = 16'd0;
        end else begin
          w_b_cnt_next = r_b_cnt + 16'd1;
        end
        w_fwd = is_forward(w_a_accept, r_a_stable, r_b_stable,
                           r_a_sync, r_b_sync) ^ INVERT;
        if (w_a_accept && w_b_accept) begin
          w_glitch_next = 1'b1;
        end else if (w_a_accept || w_b_accept) begin
          if (w_fwd) begin
            w_value_next = r_value + 2'd1;
            w_cw_next    = 1'b1;
          end else begin
            w_value_next = r_value - 2'd1;
            w_ccw_next   = 1'b1;
          end
        end else begin
          w_value_next = r_value;
        end
      end
      default: begin
        w_state_next = INIT0;
      end
    endcase
  end

  // State, debounce and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= INIT0;
      r_a_stable <= 1'b0;
      r_b_stable <= 1'b0;
      r_a_cnt    <= 16'd0;
      r_b_cnt    <= 16'd0;
      r_value    <= 2'd0;
      r_step_cw  <= 1'b0;
      r_step_ccw <= 1'b0;
      r_glitch   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_a_stable <= w_a_stable_next;
      r_b_stable <= w_b_stable_next;
      r_a_cnt    <= w_a_cnt_next;
      r_b_cnt    <= w_b_cnt_next;
      r_value    <= w_value_next;
      r_step_cw  <= w_cw_next;
      r_step_ccw <= w_ccw_next;
      r_glitch   <= w_glitch_next;
    end
  end

  assign encoder_value = r_value;
  assign step_cw       = r_step_cw;
  assign step_ccw      = r_step_ccw;
  assign glitch        = r_glitch;

endmodule

// File: tb/tb_rotary_encoder.sv
// Directed bench for rotary_encoder: a normal and an inverted instance share
// the pins; expected pulses are queued when a pin move is driven and popped
// when either instance pulses.
module tb_rotary_encoder;

  localparam int K_NONE = 0, K_CW = 1, K_CCW = 2, K_GL = 3, K_BAD = 7;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic signed [1:0] val0, val1;
  logic cw0, ccw0, gl0, cw1, ccw1, gl1;

  ev_t sb[$];
  int checks = 0;
  int errors = 0;

  rotary_encoder #(.DEBOUNCE_CYCLES(4), .INVERT(1'b0)) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .encoder_value(val0), .step_cw(cw0), .step_ccw(ccw0), .glitch(gl0));

  rotary_encoder #(.DEBOUNCE_CYCLES(4), .INVERT(1'b1)) dut_inv (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .encoder_value(val1), .step_cw(cw1), .step_ccw(ccw1), .glitch(gl1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic c, input logic w, input logic g);
    int k;
    case ({c, w, g})
      3'b000:  k = K_NONE;
      3'b100:  k = K_CW;
      3'b010:  k = K_CCW;
      3'b001:  k = K_GL;
      default: k = K_BAD;
    endcase
    return k;
  endfunction

  function automatic int swap_kind(input int k);
    if (k == K_CW) return K_CCW;
    if (k == K_CCW) return K_CW;
    return k;
  endfunction

  function automatic int wrap2(input int v);
    logic signed [1:0] t;
    t = v[1:0];
    return int'(t);
  endfunction

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int k0, k1;
    ev_t e;
    k0 = kind_of(cw0, ccw0, gl0);
    k1 = kind_of(cw1, ccw1, gl1);
    if (k0 != K_NONE || k1 != K_NONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", k0, K_NONE);
        chk("unexpected_pulse_inv", k1, K_NONE);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", k0, e.kind);
        chk("pulse_value", int'(val0), wrap2(e.val));
        chk("pulse_kind_inv", k1, swap_kind(e.kind));
        chk("pulse_value_inv", int'(val1), wrap2(-e.val));
      end
    end
  end

  // Drive a new pin pair, queue the expected event and let it settle.
  task automatic move(input logic a, input logic b, input int kind, input int val);
    ev_t e;
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.val  = val;
      sb.push_back(e);
    end
    repeat (10) @(negedge clk);
    chk("drained", sb.size(), 0);
    chk("value", int'(val0), wrap2(val));
    chk("value_inv", int'(val1), wrap2(-val));
  endtask

  initial begin
    ev_t e;
    // Reset with pins at 11; outputs must be cleared without any clock.
    #2;
    chk("rst_value", int'(val0), 0);
    chk("rst_cw", int'(cw0), 0);
    chk("rst_ccw", int'(ccw0), 0);
    chk("rst_glitch", int'(gl0), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("init_value", int'(val0), 0);
    chk("init_drained", sb.size(), 0);

    // Full forward cycle 11 -> 01 -> 00 -> 10 -> 11.
    move(1'b0, 1'b1, K_CW, 1);
    move(1'b0, 1'b0, K_CW, -2);
    move(1'b1, 1'b0, K_CW, -1);
    move(1'b1, 1'b1, K_CW, 0);

    // Bounce on A: toggles every 3 cycles, ends at its original level.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      enc_a = ~enc_a;
      repeat (2) @(negedge clk);
    end
    move(1'b1, 1'b1, K_NONE, 0);

    // Latency: A falls, edge 0 is the next rising edge; pulse after edge 5.
    @(negedge clk);
    enc_a = 1'b0;
    e.kind = K_CW;
    e.val  = 1;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("latency_early", int'(cw0), 0);
    end
    @(posedge clk);
    #1;
    chk("latency_pulse", int'(cw0), 1);
    chk("latency_value", int'(val0), 1);
    repeat (6) @(negedge clk);
    chk("latency_drained", sb.size(), 0);

    // From 00, both channels flip together: glitch only.
    move(1'b0, 1'b0, K_CW, -2);
    move(1'b1, 1'b1, K_GL, -2);

    // Return to 0, then three reverse steps with wrap.
    move(1'b0, 1'b1, K_CW, -1);
    move(1'b0, 1'b0, K_CW, 0);
    move(1'b0, 1'b1, K_CCW, -1);
    move(1'b1, 1'b1, K_CCW, -2);
    move(1'b1, 1'b0, K_CCW, 1);

    // Reset while the debounce counter sits at 3 with a pending edge.
    @(negedge clk);
    enc_a = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_value", int'(val0), 0);
    chk("midrst_value_inv", int'(val1), 0);
    chk("midrst_pulses", int'({cw0, ccw0, gl0}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    chk("postrst_value", int'(val0), 0);
    chk("postrst_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
